// File: rtl/booth_mult_r4_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// The master drives the request side; the multiplier (slave) returns prod/busy/done.
interface booth_mult_r4_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   mp;
  logic [2*WIDTH-1:0] prod;
  logic               busy;
  logic               done;

  modport master (
    output start, signed_mode, mc, mp,
    input  prod, busy, done
  );

  modport slave (
    input  start, signed_mode, mc, mp,
    output prod, busy, done
  );
endinterface

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier, signed or unsigned chosen per operation.
// Fixed latency: two multiplier bits are retired per RUN cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; operands and mode captured on accept
// RUN    | one Booth digit per edge, NITER edges in total
// FINISH | publish product, pulse done, drop busy
module booth_mult_r4 #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  booth_mult_r4_if.slave bus
);

  localparam int NITER = WIDTH / 2 + 1;
  localparam int IW    = $clog2(NITER + 1);
  localparam int XW    = WIDTH + 2;
  localparam int AW    = WIDTH + 3;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_mult_r4: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      mc_x;
  logic [XW-1:0]      q;
  logic               qm1;
  logic [AW-1:0]      acc;
  logic [IW-1:0]      iter;
  logic [2*WIDTH-1:0] prod_q;
  logic               busy_q;
  logic               done_q;

  logic               load;
  logic               step;
  logic               fin;
  logic               ext_mc;
  logic               ext_mp;
  logic [AW-1:0]      mc_a;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_nxt;
  logic [XW-1:0]      q_nxt;
  logic [2*WIDTH-1:0] prod_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (iter == IW'(NITER - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        fin     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two guard bits on the operands keep unsigned values positive in the
  // signed recoding, and the third acc bit absorbs the +/-2M digit.
  assign ext_mc = bus.signed_mode & bus.mc[WIDTH-1];
  assign ext_mp = bus.signed_mode & bus.mp[WIDTH-1];
  assign mc_a   = {mc_x[XW-1], mc_x};

  always_comb begin
    addend = '0;
    case ({q[1], q[0], qm1})
      3'b001, 3'b010: addend = mc_a;
      3'b011:         addend = mc_a << 1;
      3'b100:         addend = -(mc_a << 1);
      3'b101, 3'b110: addend = -mc_a;
      default:        addend = '0;
    endcase
  end

  assign sum      = acc + addend;
  assign acc_nxt  = {sum[AW-1], sum[AW-1], sum[AW-1:2]};
  assign q_nxt    = {sum[1:0], q[XW-1:2]};
  assign prod_nxt = {acc[WIDTH-3:0], q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc_x   <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      acc    <= '0;
      iter   <= '0;
      prod_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        mc_x   <= {{2{ext_mc}}, bus.mc};
        q      <= {{2{ext_mp}}, bus.mp};
        qm1    <= 1'b0;
        acc    <= '0;
        iter   <= '0;
        busy_q <= 1'b1;
      end
      if (step) begin
        acc  <= acc_nxt;
        q    <= q_nxt;
        qm1  <= q[1];
        iter <= iter + IW'(1);
      end
      if (fin) begin
        prod_q <= prod_nxt;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.prod = prod_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
